// File: rtl/dec_pkg.sv
// Shared constants and state encoding for the pulsed 3-to-8 decoder.
package dec_pkg;

  localparam int CODE_W   = 3;
  localparam int ONEHOT_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/dec3to8_pulse_dec.sv
// Combinational 3-to-8 one-hot decoder, gated by enable.
module dec3to8
  import dec_pkg::*;
(
  input  logic                din,
  input  logic [CODE_W-1:0]   code,
  output logic [ONEHOT_W-1:0] onehot
);

  always_comb begin
    onehot = '0;
    if (din) onehot[code] = 1'b1;
  end

endmodule

// File: rtl/dec3to8_pulse.sv
// Handshaked 3-to-8 decoder: holds the one-hot line for HOLD_CYCLES, pulses done,
// then waits GAP_CYCLES before accepting again. Counts accepted codes.
module dec3to8_pulse
  import dec_pkg::*;
#(
  parameter int HOLD_CYCLES = 4,
  parameter int GAP_CYCLES  = 1,
  parameter int CNT_W       = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                EN,
  input  logic [CODE_W-1:0]   Din,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [ONEHOT_W-1:0] Dout,
  output logic                busy,
  output logic                done,
  output logic [CNT_W-1:0]    count
);

  localparam int TW = $clog2(max2(HOLD_CYCLES, GAP_CYCLES)) + 1;
  localparam logic [TW-1:0] HOLD_LOAD = TW'(HOLD_CYCLES - 1);
  localparam logic [TW-1:0] GAP_LOAD  = TW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  state_t                state_q, state_d;
  logic [TW-1:0]         tmr_q, tmr_d;
  logic [ONEHOT_W-1:0]   dout_q, dout_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [ONEHOT_W-1:0]   dec_onehot;
  logic                  accept;

  dec3to8 u_dec (
    .din    (EN),
    .code   (Din),
    .onehot (dec_onehot)
  );

  assign in_ready = EN & ~rst & (state_q == ST_IDLE);
  assign accept   = in_valid & in_ready;

  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    dout_d  = dout_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    count_d = count_q;

    if (!EN) begin
      // Abort: no done pulse, count kept.
      state_d = ST_IDLE;
      dout_d  = '0;
      busy_d  = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            state_d = ST_HOLD;
            tmr_d   = HOLD_LOAD;
            dout_d  = dec_onehot;
            busy_d  = 1'b1;
            count_d = count_q + CNT_W'(1);
          end
        end
        ST_HOLD: begin
          if (tmr_q == '0) begin
            dout_d = '0;
            done_d = 1'b1;
            if (GAP_CYCLES == 0) begin
              state_d = ST_IDLE;
              busy_d  = 1'b0;
            end else begin
              state_d = ST_GAP;
              tmr_d   = GAP_LOAD;
            end
          end else begin
            tmr_d = tmr_q - TW'(1);
          end
        end
        ST_GAP: begin
          if (tmr_q == '0) begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
          end else begin
            tmr_d = tmr_q - TW'(1);
          end
        end
        default: begin
          state_d = ST_IDLE;
          dout_d  = '0;
          busy_d  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      tmr_q   <= '0;
      dout_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      dout_q  <= dout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      count_q <= count_d;
    end
  end

  assign Dout  = dout_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign count = count_q;

endmodule

// File: tb/tb_dec3to8_pulse.sv
// Bench for dec3to8_pulse: timeline-based reference model plus directed and random stimulus.
module tb_dec3to8_pulse;

  localparam int H     = 4;
  localparam int G     = 1;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             EN = 1'b0;
  logic [2:0]       Din = '0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [7:0]       Dout;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] count;

  int n_checks = 0;
  int n_err    = 0;

  // model: cycles elapsed since the last accept, and whether that pulse is still alive
  bit m_active = 0;
  int m_k      = 0;
  int m_code   = 0;
  int m_count  = 0;
  bit m_done   = 0;

  dec3to8_pulse #(.HOLD_CYCLES(H), .GAP_CYCLES(G), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .EN(EN), .Din(Din), .in_valid(in_valid),
    .in_ready(in_ready), .Dout(Dout), .busy(busy), .done(done), .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always begin
    logic [7:0] e_dout;
    @(posedge clk);
    m_done = 0;
    if (rst) begin
      m_active = 0;
      m_count  = 0;
    end else if (!EN) begin
      m_active = 0;
    end else if (m_active) begin
      if (m_k == H) m_done = 1;
      m_k++;
      if (m_k > H + G) m_active = 0;
    end else if (in_valid) begin
      m_active = 1;
      m_k      = 1;
      m_code   = int'(Din);
      m_count  = (m_count + 1) % (1 << CNT_W);
    end
    #1;
    e_dout = '0;
    if (m_active && m_k <= H) e_dout[m_code] = 1'b1;
    chk("model_dout",  int'(Dout),  int'(e_dout));
    chk("model_busy",  int'(busy),  int'(m_active && m_k <= H + G));
    chk("model_done",  int'(done),  int'(m_done));
    chk("model_count", int'(count), m_count);
    @(negedge clk);
    chk("model_ready", int'(in_ready), int'(EN && !rst && !m_active));
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic do_accept(input logic [2:0] code);
    bit ok = 0;
    Din      = code;
    in_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      #1;
      if (in_ready) begin
        @(posedge clk);
        #2;
        ok = 1;
        break;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!ok) begin
      n_checks++;
      n_err++;
      $display("FAIL accept_timeout: in_ready never rose for code %0d", code);
    end
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 20 && busy; i++) step();
  endtask

  initial begin
    rst = 1'b1;
    step();
    step();
    chk("reset_dout", int'(Dout), 0);
    chk("reset_count", int'(count), 0);
    chk("reset_ready", int'(in_ready), 0);
    rst = 1'b0;
    EN  = 1'b1;
    step();

    // single accept of code 5
    do_accept(3'd5);
    for (int i = 0; i < H; i++) begin
      chk("t1_dout_hold", int'(Dout), 8'h20);
      step();
    end
    chk("t1_dout_clear", int'(Dout), 0);
    chk("t1_done", int'(done), 1);
    chk("t1_count", int'(count), 1);
    wait_idle();

    // all codes back-to-back
    for (int c = 0; c < 8; c++) begin
      do_accept(3'(c));
      chk("t2_walk", int'(Dout), 1 << c);
    end
    wait_idle();
    step();
    chk("t2_count", int'(count), 9);

    // EN dropped in second hold cycle
    do_accept(3'd7);
    step();
    EN = 1'b0;
    step();
    chk("t3_dout_abort", int'(Dout), 0);
    chk("t3_busy_abort", int'(busy), 0);
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("t3_ready_low", int'(in_ready), 0);
      chk("t3_done_low", int'(done), 0);
      step();
    end
    chk("t3_count", int'(count), 10);
    in_valid = 1'b0;
    EN = 1'b1;
    step();

    // Din changes during hold
    do_accept(3'd2);
    Din = 3'd6;
    in_valid = 1'b1;
    for (int i = 0; i < H; i++) begin
      chk("t4_dout_stable", int'(Dout), 8'h04);
      step();
    end
    in_valid = 1'b0;
    wait_idle();
    step();

    // reset during GAP
    do_accept(3'd3);
    for (int i = 0; i < H; i++) step();
    chk("t5_in_gap", int'(busy), 1);
    rst = 1'b1;
    step();
    chk("t5_dout_rst", int'(Dout), 0);
    chk("t5_busy_rst", int'(busy), 0);
    chk("t5_count_rst", int'(count), 0);
    rst = 1'b0;
    Din = 3'd1;
    in_valid = 1'b1;
    #1;
    chk("t5_ready_after_rst", int'(in_ready), 1);
    step();
    in_valid = 1'b0;
    chk("t5_accept", int'(Dout), 8'h02);
    wait_idle();

    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      rst      = ($urandom_range(0, 99) == 0);
      EN       = ($urandom_range(0, 15) != 0);
      in_valid = $urandom_range(0, 1);
      Din      = 3'($urandom_range(0, 7));
      step();
    end

    // counter wrap after 256 accepts
    rst = 1'b1;
    EN  = 1'b1;
    in_valid = 1'b0;
    step();
    rst = 1'b0;
    for (int i = 0; i < 256; i++) do_accept(3'($urandom_range(0, 7)));
    chk("t6_wrap", int'(count), 0);
    wait_idle();
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
